// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - State encoding and shared constants for the chess-training control unit (PAUSA under PROJ_UC_PAUSA_EN)
package proj_pkg;

  localparam int DB_ESTADO_W = 4;

  typedef enum logic [DB_ESTADO_W-1:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    NOVA     = 4'd2,
    ESPERA   = 4'd3,
    REGISTRA = 4'd4,
    COMPARA  = 4'd5,
    ACERTO   = 4'd6,
    ERRO     = 4'd7,
    PROXIMA  = 4'd8,
    FIM_JOGO = 4'd9
`ifdef PROJ_UC_PAUSA_EN
    ,
    PAUSA    = 4'd10
`endif
  } estado_t;

endpackage

// File: rtl/contador_rodadas.sv
// rtl/contador_rodadas.sv - Saturating round counter with synchronous clear and terminal-count flag
module contador_rodadas #(
  parameter int NUM_RODADAS = 8,
  parameter int W_RODADA    = 8
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_zera,
  input  logic                i_conta,
  output logic [W_RODADA-1:0] o_q,
  output logic                o_fim
);

  localparam logic [W_RODADA-1:0] LIMITE = W_RODADA'(NUM_RODADAS);

  logic [W_RODADA-1:0] r_cont;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cont <= '0;
    end else if (i_zera) begin
      r_cont <= '0;
    end else if (i_conta && (r_cont != LIMITE)) begin
      r_cont <= r_cont + 1'b1;
    end
  end

  assign o_q   = r_cont;
  assign o_fim = (r_cont == LIMITE);

endmodule

// File: rtl/proj_unidade_controle.sv
// rtl/proj_unidade_controle.sv - Moore FSM sequencing the chess-training datapath (pause state under PROJ_UC_PAUSA_EN)
module proj_unidade_controle
  import proj_pkg::*;
#(
  parameter int NUM_RODADAS = 8,
  parameter int W_RODADA    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   fimT,
  input  logic                   acertou,
  input  logic                   temJogada,
`ifdef PROJ_UC_PAUSA_EN
  input  logic                   pausa,
`endif
  output logic                   zeraT,
  output logic                   zeraR,
  output logic                   zeraP,
  output logic                   contaT,
  output logic                   decresceT,
  output logic                   contaP,
  output logic                   registraR,
  output logic                   novaJogada,
  output logic                   pronto,
  output logic [W_RODADA-1:0]    rodada,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    w_fim_rodadas;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_proximo;
  end

  // Round counter moves on entry, so rodada is already current in PREPARA/ACERTO
  contador_rodadas #(
    .NUM_RODADAS (NUM_RODADAS),
    .W_RODADA    (W_RODADA)
  ) u_contador_rodadas (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_zera    (w_proximo == PREPARA),
    .i_conta   (w_proximo == ACERTO),
    .o_q       (rodada),
    .o_fim     (w_fim_rodadas)
  );

  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:  w_proximo = iniciar ? PREPARA : INICIAL;
      PREPARA:  w_proximo = NOVA;
      NOVA:     w_proximo = ESPERA;
      ESPERA: begin
        if (fimT)           w_proximo = FIM_JOGO;
        else if (temJogada) w_proximo = REGISTRA;
`ifdef PROJ_UC_PAUSA_EN
        else if (pausa)     w_proximo = PAUSA;
`endif
        else                w_proximo = ESPERA;
      end
      REGISTRA: w_proximo = COMPARA;
      COMPARA: begin
        if (fimT)         w_proximo = FIM_JOGO;
        else if (acertou) w_proximo = ACERTO;
        else              w_proximo = ERRO;
      end
      ACERTO:   w_proximo = PROXIMA;
      ERRO:     w_proximo = ESPERA;
      PROXIMA:  w_proximo = w_fim_rodadas ? FIM_JOGO : NOVA;
      FIM_JOGO: w_proximo = iniciar ? PREPARA : FIM_JOGO;
`ifdef PROJ_UC_PAUSA_EN
      PAUSA:    w_proximo = pausa ? PAUSA : ESPERA;
`endif
      default:  w_proximo = INICIAL;
    endcase
  end

  always_comb begin
    zeraT      = 1'b0;
    zeraR      = 1'b0;
    zeraP      = 1'b0;
    contaT     = 1'b0;
    decresceT  = 1'b0;
    contaP     = 1'b0;
    registraR  = 1'b0;
    novaJogada = 1'b0;
    pronto     = 1'b0;
    case (r_estado)
      PREPARA: begin
        zeraT = 1'b1;
        zeraR = 1'b1;
        zeraP = 1'b1;
      end
      NOVA: begin
        novaJogada = 1'b1;
        zeraR      = 1'b1;
      end
      ESPERA:  contaT = 1'b1;
      REGISTRA: begin
        registraR = 1'b1;
        contaT    = 1'b1;
      end
      COMPARA: contaT = 1'b1;
      ACERTO: begin
        contaP    = 1'b1;
        decresceT = 1'b1;
      end
      ERRO:     zeraR  = 1'b1;
      FIM_JOGO: pronto = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = r_estado;

endmodule

// File: tb/tb_proj_unidade_controle.sv
// tb/tb_proj_unidade_controle.sv - Directed self-checking bench for proj_unidade_controle (pause steps under PROJ_UC_PAUSA_EN)
module tb_proj_unidade_controle;

  localparam int NR = 3;
  localparam int W  = 8;

  // Strobe vector order: zeraT zeraR zeraP contaT decresceT contaP registraR novaJogada pronto
  localparam logic [8:0] S_NONE   = 9'b000_000_000;
  localparam logic [8:0] S_PREP   = 9'b111_000_000;
  localparam logic [8:0] S_NOVA   = 9'b010_000_010;
  localparam logic [8:0] S_CONTA  = 9'b000_100_000;
  localparam logic [8:0] S_REG    = 9'b000_100_100;
  localparam logic [8:0] S_ACERTO = 9'b000_011_000;
  localparam logic [8:0] S_ERRO   = 9'b010_000_000;
  localparam logic [8:0] S_FIM    = 9'b000_000_001;

  logic clock = 1'b0;
  logic reset, iniciar, fimT, acertou, temJogada;
`ifdef PROJ_UC_PAUSA_EN
  logic pausa;
`endif
  logic zeraT, zeraR, zeraP, contaT, decresceT, contaP, registraR, novaJogada, pronto;
  logic [W-1:0] rodada;
  logic [3:0]   db_estado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  proj_unidade_controle #(.NUM_RODADAS(NR), .W_RODADA(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .fimT       (fimT),
    .acertou    (acertou),
    .temJogada  (temJogada),
`ifdef PROJ_UC_PAUSA_EN
    .pausa      (pausa),
`endif
    .zeraT      (zeraT),
    .zeraR      (zeraR),
    .zeraP      (zeraP),
    .contaT     (contaT),
    .decresceT  (decresceT),
    .contaP     (contaP),
    .registraR  (registraR),
    .novaJogada (novaJogada),
    .pronto     (pronto),
    .rodada     (rodada),
    .db_estado  (db_estado)
  );

  wire [8:0] w_strobes = {zeraT, zeraR, zeraP, contaT, decresceT, contaP, registraR, novaJogada, pronto};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [3:0] db, input logic [8:0] s);
    chk({tag, "_estado"}, 32'(db_estado), 32'(db));
    chk({tag, "_saidas"}, 32'(w_strobes), 32'(s));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Entered in ESPERA; leaves the FSM in ESPERA (or FIM_JOGO when ultima)
  task automatic jogada_certa(input string tag, input int rod_apos, input bit ultima);
    acertou = 1'b1; temJogada = 1'b1;
    step(); temJogada = 1'b0;
    st({tag, "_reg"}, 4'd4, S_REG);
    step(); st({tag, "_cmp"}, 4'd5, S_CONTA);
    step(); st({tag, "_acerto"}, 4'd6, S_ACERTO);
    step(); st({tag, "_prox"}, 4'd8, S_NONE);
    chk({tag, "_rodada"}, 32'(rodada), 32'(rod_apos));
    step();
    if (ultima) begin
      st({tag, "_fim"}, 4'd9, S_FIM);
    end else begin
      st({tag, "_nova"}, 4'd2, S_NOVA);
      step(); st({tag, "_espera"}, 4'd3, S_CONTA);
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; fimT = 1'b0; acertou = 1'b0; temJogada = 1'b0;
`ifdef PROJ_UC_PAUSA_EN
    pausa = 1'b0;
`endif
    step(); step(); step();
    st("reset", 4'd0, S_NONE);
    chk("reset_rodada", 32'(rodada), 32'd0);

    reset = 1'b1;
    temJogada = 1'b1;
    step(); temJogada = 1'b0;
    st("ignora_jogada", 4'd0, S_NONE);

    iniciar = 1'b1;
    step(); iniciar = 1'b0;
    st("prepara", 4'd1, S_PREP);
    step(); st("nova", 4'd2, S_NOVA);
    chk("nova_rodada", 32'(rodada), 32'd0);
    step(); st("espera", 4'd3, S_CONTA);
    step(); st("espera_fica", 4'd3, S_CONTA);

    jogada_certa("certa1", 1, 1'b0);

    acertou = 1'b0; temJogada = 1'b1;
    step(); temJogada = 1'b0;
    st("errada_reg", 4'd4, S_REG);
    step(); st("errada_cmp", 4'd5, S_CONTA);
    step(); st("errada_erro", 4'd7, S_ERRO);
    step(); st("errada_espera", 4'd3, S_CONTA);
    chk("errada_rodada", 32'(rodada), 32'd1);

    jogada_certa("certa2", 2, 1'b0);

    fimT = 1'b1; temJogada = 1'b1;
    step(); fimT = 1'b0; temJogada = 1'b0;
    st("timeout", 4'd9, S_FIM);
    step(); st("timeout_fica", 4'd9, S_FIM);
    chk("timeout_rodada", 32'(rodada), 32'd2);

    iniciar = 1'b1;
    step(); iniciar = 1'b0;
    st("reinicio_prepara", 4'd1, S_PREP);
    step(); st("reinicio_nova", 4'd2, S_NOVA);
    chk("reinicio_rodada", 32'(rodada), 32'd0);
    step(); st("reinicio_espera", 4'd3, S_CONTA);

    jogada_certa("jogo1", 1, 1'b0);
    jogada_certa("jogo2", 2, 1'b0);
    jogada_certa("jogo3", 3, 1'b1);
    chk("jogo_rodada_final", 32'(rodada), 32'd3);
    step(); st("jogo_fim_fica", 4'd9, S_FIM);

    iniciar = 1'b1;
    step(); iniciar = 1'b0;
    st("jogo_prepara", 4'd1, S_PREP);
    step(); st("jogo_nova", 4'd2, S_NOVA);
    chk("jogo_rodada_zero", 32'(rodada), 32'd0);
    step(); st("jogo_espera", 4'd3, S_CONTA);

`ifdef PROJ_UC_PAUSA_EN
    pausa = 1'b1;
    step(); st("pausa", 4'd10, S_NONE);
    step(); st("pausa_fica", 4'd10, S_NONE);
    pausa = 1'b0;
    step(); st("pausa_sai", 4'd3, S_CONTA);
`endif

    acertou = 1'b1; temJogada = 1'b1;
    step(); temJogada = 1'b0;
    step(); st("meio_cmp", 4'd5, S_CONTA);
    #2 reset = 1'b0;
    #1 st("meio_reset", 4'd0, S_NONE);
    chk("meio_reset_rodada", 32'(rodada), 32'd0);
    step(); reset = 1'b1;
    step(); st("meio_inicial", 4'd0, S_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proj_unidade_controle.md
Name: proj_unidade_controle

Overview:
- Moore FSM that sequences the chess-training datapath: clears it, requests target squares from the move generator, runs the round timer, captures the player's move, and scores it.
- Tracks the number of correct moves against a fixed round count; ends the game on timeout or when all rounds are done.
- Sits beside proj_fluxo_dados in the top level; all datapath strobes come from this block.

Parameters:
- NUM_RODADAS, 8, correct moves needed to finish a game (1..255).
- W_RODADA, 8, width of the internal round counter; must satisfy NUM_RODADAS < 2**W_RODADA.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, level; sampled only in INICIAL / FIM_JOGO.
- fimT  in  1  round timer expired (datapath).
- acertou  in  1  registered move equals expected move (datapath).
- temJogada  in  1  one-cycle pulse, player committed a move (datapath).
- zeraT, zeraR, zeraP  out  1  synchronous clears for timer, move registers / edge detector, and score.
- contaT  out  1  timer count enable.
- decresceT  out  1  timer decrement pulse (time bonus).
- contaP  out  1  score increment pulse.
- registraR  out  1  load move registers.
- novaJogada  out  1  request next target from generator.
- pronto  out  1  game over.
- rodada  out  W_RODADA  correct moves in the current game.
- db_estado  out  4  state code, debug.

Behaviour:
- State codes: INICIAL=0, PREPARA=1, NOVA=2, ESPERA=3, REGISTRA=4, COMPARA=5, ACERTO=6, ERRO=7, PROXIMA=8, FIM_JOGO=9. Unused codes go to INICIAL on the next clock.
- Outputs are decoded from the state only (Moore); every output asserts in the same cycle the state is entered. `rodada` is a register.
- While reset=0: state=INICIAL, rodada=0, all outputs 0, db_estado=0.
- INICIAL:
  - All strobes 0.
  - iniciar=1 → PREPARA.
- PREPARA:
  - zeraT=zeraR=zeraP=1; rodada cleared.
  - Next state: NOVA.
- NOVA:
  - novaJogada=1, zeraR=1.
  - Next state: ESPERA.
- ESPERA:
  - contaT=1.
  - fimT=1 → FIM_JOGO. This has priority over a temJogada in the same cycle.
  - Otherwise temJogada=1 → REGISTRA.
  - Otherwise stay in ESPERA.
- REGISTRA:
  - registraR=1; contaT=1, so the timer keeps running.
  - Next state: COMPARA.
- COMPARA:
  - contaT=1.
  - fimT=1 → FIM_JOGO.
  - Otherwise acertou=1 → ACERTO; acertou=0 → ERRO.
- ACERTO:
  - contaP=1, decresceT=1 (exactly one cycle); rodada+1.
  - Next state: PROXIMA.
- ERRO:
  - zeraR=1, so the edge detector re-arms.
  - Next state: ESPERA. The same target stays active; no new move is requested.
- PROXIMA:
  - rodada==NUM_RODADAS → FIM_JOGO; otherwise → NOVA.
- FIM_JOGO:
  - pronto=1; all other strobes 0. Timer and score hold.
  - iniciar=1 → PREPARA.
- Latency:
  - temJogada to contaP is 3 cycles (REGISTRA, COMPARA, ACERTO).
  - A correct move to the next novaJogada is 5 cycles.
- rodada saturates at NUM_RODADAS and never wraps.
- A temJogada pulse outside ESPERA is ignored.
- Reset asserted mid-game aborts immediately to INICIAL; the datapath is cleared on the next PREPARA.

Optional Feature:
- Macro: PROJ_UC_PAUSA_EN.
- When defined:
  - Adds input `pausa` (1 bit) and state PAUSA=10.
  - From ESPERA, pausa=1 → PAUSA. This has the lowest priority, below fimT and temJogada.
  - In PAUSA all strobes are 0 (the timer is frozen); pausa=0 → ESPERA.
  - db_estado reports 10 while paused.
- When undefined: no `pausa` port and no PAUSA state; state code 10 is unused and recovers to INICIAL.

Decomposition:
- Package proj_pkg holds:
  - the state enum, 4 bits, with the explicit codes above;
  - the constant DB_ESTADO_W=4.
- One natural sub-module: contador_rodadas. It is a W_RODADA-bit counter with zera, conta, and a fim output (count==NUM_RODADAS), reusable beside contador_m.
- The FSM next-state logic and output decode stay in this module.

Test Plan:
- Reset and start: reset=0 for 3 cycles → db_estado=0, all outputs 0. Release reset, iniciar=1 → PREPARA asserts zeraT/zeraR/zeraP for 1 cycle, then NOVA asserts novaJogada for 1 cycle, then ESPERA with contaT=1.
- Correct move: temJogada pulse with acertou=1 → registraR at +1 cycle, contaP and decresceT at +3 cycles, rodada 0→1, novaJogada at +5 cycles.
- Wrong move: temJogada with acertou=0 → ERRO asserts zeraR, returns to ESPERA, no novaJogada, contaP never asserts, rodada unchanged.
- Timeout priority: fimT=1 in the same cycle as temJogada in ESPERA → FIM_JOGO next cycle, pronto=1, registraR never asserts.
- Full game, NUM_RODADAS=3: three correct moves → pronto=1 after the third ACERTO+PROXIMA, rodada=3. iniciar=1 → PREPARA, rodada=0.
- Mid-game reset and pause: reset=0 in COMPARA → outputs 0 asynchronously. With PROJ_UC_PAUSA_EN defined, pausa=1 in ESPERA → contaT=0 and db_estado=10; pausa=0 → ESPERA.
